// File: rtl/codificador_instr_pkg.sv
// Tipo codes, RV32I opcodes and field layout shared by the instruction
// encoder and the control decoder.
package codificador_instr_pkg;

   typedef enum logic [2:0] {
      TIPO_I = 3'd0,
      TIPO_R = 3'd1,
      TIPO_S = 3'd2,
      TIPO_L = 3'd3,
      TIPO_B = 3'd4,
      TIPO_J = 3'd5
   } tipo_e;

   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_J = 7'b1101111;

   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;

   function automatic logic tipo_legal(input logic [2:0] t);
      return t <= TIPO_J;
   endfunction

   function automatic logic [31:0] encode(
      input logic [2:0]  t,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [31:0] imm
   );
      logic [31:0] w;
      w = '0;
      case (t)
         TIPO_I: w = {imm[11:0], rs1, f3, rd, OP_I};
         TIPO_L: w = {imm[11:0], rs1, f3, rd, OP_L};
         TIPO_R: w = {f7, rs2, rs1, f3, rd, OP_R};
         TIPO_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
         TIPO_B: w = {imm[12], imm[10:5], rs2, rs1, f3,
                      imm[4:1], imm[11], OP_B};
         TIPO_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
         default: w = '0;
      endcase
      return w;
   endfunction

   // Sign-extension check: bits above the field must copy its sign bit.
   function automatic logic imm_fits(
      input logic [2:0]  t,
      input logic [31:0] imm
   );
      logic ok;
      ok = 1'b1;
      case (t)
         TIPO_I, TIPO_L, TIPO_S: ok = imm[31:11] == {21{imm[11]}};
         TIPO_B: ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
         TIPO_J: ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/codificador_instr_fifo.sv
// fifo_instr: DEPTH-entry valid/ready word buffer with full/empty flags.
// A write into a full FIFO is ignored even if a pop happens that cycle.
module fifo_instr #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;

   assign empty_o = wr_q == rd_q;
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      mem_d = mem_q;
      if (clear_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_i && !full_o) begin
            mem_d[wr_q[AW-1:0]] = data_i;
            wr_d = wr_q + (AW+1)'(1);
         end
         if (pop_i && !empty_o) begin
            rd_d = rd_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/codificador_instr.sv
// RV32I instruction encoder streaming words with byte addresses to the
// imem loader. Define ENC_RANGE_CHK_EN to reject out-of-range immediates.
module codificador_instr
   import codificador_instr_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        tipo_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [31:0]       imm_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [15:0]       count_o,
   output logic              err_o
);

   localparam int W = 32 + ADDR_W;

   logic              full, empty;
   logic              imm_ok, legal, accept, push, pop;
   logic [31:0]       word;
   logic [W-1:0]      head;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       count_q, count_d;
   logic              err_q, err_d;

`ifdef ENC_RANGE_CHK_EN
   assign imm_ok = imm_fits(tipo_i, imm_i);
`else
   logic unused_imm;
   assign imm_ok     = 1'b1;
   assign unused_imm = ^imm_i[31:21];
`endif

   assign ready_o = !full;
   assign valid_o = !empty;
   assign accept  = valid_i && ready_o;
   assign legal   = tipo_legal(tipo_i) && imm_ok;
   assign push    = accept && legal && !clear_i;
   assign pop     = valid_o && ready_i && !clear_i;
   assign word    = encode(tipo_i, rd_i, rs1_i, rs2_i,
                           funct3_i, funct7_i, imm_i);

   // Address is bound at enqueue; when empty, show the next one to go out.
   assign instr_o = empty ? '0 : head[W-1 -: 32];
   assign addr_o  = empty ? addr_q : head[ADDR_W-1:0];
   assign count_o = count_q;
   assign err_o   = err_q;

   fifo_instr #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({word, addr_q}),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      if (clear_i) begin
         addr_d  = BASE_ADDR;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (push) begin
            addr_d = addr_q + ADDR_W'(4);
         end
         if (pop && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
         end
         if (accept && !legal) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule
